// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and types for the stopwatch time counter
// Purpose: prescaler default, BCD digit limits, display state encoding and the
//          nibble offsets of each digit inside display_Digits.
// Ports:   none (package).
package stopwatch_pkg;

    localparam int TICK_DIV_DEFAULT = 1_000_000;
    localparam int MIN_MAX_DEFAULT  = 59;

    localparam int DIGIT_MAX_9 = 9;
    localparam int DIGIT_MAX_5 = 5;

    localparam int DISP_W = 24;

    // display_Digits = {m10, m1, s10, s1, h10, h1}
    localparam int H1_LSB  = 0;
    localparam int H10_LSB = 4;
    localparam int S1_LSB  = 8;
    localparam int S10_LSB = 12;
    localparam int M1_LSB  = 16;
    localparam int M10_LSB = 20;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } disp_state_e;

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// rtl/stopwatch_time_counter_if.sv - control/display bundle of the stopwatch time counter
// Purpose: groups the button-FSM controls and the display-side outputs.
// Ports:   master drives count_Enable/clear/split and observes the outputs;
//          slave (the counter) does the reverse.
interface stopwatch_time_counter_if;
    import stopwatch_pkg::*;

    logic              count_Enable;
    logic              clear;
    logic              split;
    logic [DISP_W-1:0] display_Digits;
    logic              running;
    logic              held;
    logic              rollover;

    modport master (
        output count_Enable, clear, split,
        input  display_Digits, running, held, rollover
    );

    modport slave (
        input  count_Enable, clear, split,
        output display_Digits, running, held, rollover
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit counting 0..MAX with carry out
// Purpose: one decade (or sexagesimal tens) stage of the elapsed-time chain.
// Ports:   clk, reset_n (sync active-low), inc (advance), clr (sync clear, wins
//          over inc), q (digit value), carry (inc while at MAX, i.e. wrapping).
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DIGIT_MAX_9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign carry = inc & (q_q == 4'(MAX));
    assign q     = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc) begin
            q_d = (q_q == 4'(MAX)) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// rtl/stopwatch_time_counter.sv - MM:SS.hh BCD elapsed-time counter with split hold
// Purpose: 1/100 s prescaler, six cascaded BCD digits, LIVE/HELD display register
//          and a one-cycle rollover pulse on MIN_MAX:59.99 -> 00:00.00.
// Ports:   clock100MHz, reset_n (sync active-low), sw (slave side of the
//          stopwatch_time_counter_if bundle: controls in, display/status out).
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int MIN_MAX  = MIN_MAX_DEFAULT
) (
    input  logic                     clock100MHz,
    input  logic                     reset_n,
    stopwatch_time_counter_if.slave  sw
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic              presc_at_max;
    logic              tick;
    logic              wrap;
    logic              min_clr;
    logic              minutes_at_max;

    logic [3:0]        h1, h10, s1, s10, m1, m10;
    logic              c_h1, c_h10, c_s1, c_s10, c_m1, c_m10;
    logic [DISP_W-1:0] digits;

    disp_state_e       state_q;
    logic [DISP_W-1:0] disp_q;
    logic              running_q;
    logic              rollover_q;

    assign presc_at_max = (presc_q == PRESC_LAST);
    // Clear dominates, so a tick is suppressed in a clear cycle.
    assign tick = sw.count_Enable & presc_at_max & ~sw.clear;

    // The prescaler only holds while paused, so a pause never restarts the period.
    always_comb begin
        presc_d = presc_q;
        if (sw.clear) begin
            presc_d = '0;
        end else if (sw.count_Enable) begin
            presc_d = presc_at_max ? '0 : presc_q + PW'(1);
        end
    end

    // Minutes wrap at MIN_MAX rather than at the natural m10 limit; with the
    // default 59 both terms describe the same cycle.
    assign minutes_at_max = ({m10, m1} == {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)});
    assign wrap           = c_m10 | (c_s10 & minutes_at_max);
    assign min_clr        = sw.clear | wrap;

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_h1 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(tick),  .clr(sw.clear), .q(h1),  .carry(c_h1)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_h10 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(c_h1),  .clr(sw.clear), .q(h10), .carry(c_h10)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_s1 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(c_h10), .clr(sw.clear), .q(s1),  .carry(c_s1)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_s10 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(c_s1),  .clr(sw.clear), .q(s10), .carry(c_s10)
    );
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_m1 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(c_s10), .clr(min_clr),  .q(m1),  .carry(c_m1)
    );
    bcd_digit_counter #(.MAX(MIN_MAX / 10)) u_m10 (
        .clk(clock100MHz), .reset_n(reset_n), .inc(c_m1),  .clr(min_clr),  .q(m10), .carry(c_m10)
    );

    always_comb begin
        digits                    = '0;
        digits[H1_LSB  +: 4]      = h1;
        digits[H10_LSB +: 4]      = h10;
        digits[S1_LSB  +: 4]      = s1;
        digits[S10_LSB +: 4]      = s10;
        digits[M1_LSB  +: 4]      = m1;
        digits[M10_LSB +: 4]      = m10;
    end

    // Display FSM plus status registers. The display captures the pre-tick
    // digit value, so a split coinciding with a tick freezes the older time.
    always_ff @(posedge clock100MHz) begin
        if (!reset_n) begin
            presc_q    <= '0;
            state_q    <= LIVE;
            disp_q     <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            running_q  <= sw.count_Enable;
            rollover_q <= wrap;
            if (sw.clear) begin
                state_q <= LIVE;
                disp_q  <= '0;
            end else begin
                case (state_q)
                    LIVE: begin
                        disp_q <= digits;
                        if (sw.split) begin
                            state_q <= HELD;
                        end
                    end
                    HELD: begin
                        if (sw.split) begin
                            state_q <= LIVE;
                            disp_q  <= digits;
                        end
                    end
                    default: begin
                        state_q <= LIVE;
                    end
                endcase
            end
        end
    end

    assign sw.display_Digits = disp_q;
    assign sw.running        = running_q;
    assign sw.held           = (state_q == HELD);
    assign sw.rollover       = rollover_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb/tb_stopwatch_time_counter.sv - directed vector bench for stopwatch_time_counter
module tb_stopwatch_time_counter;

    logic clk;
    logic rst_n;

    stopwatch_time_counter_if sw_if ();
    stopwatch_time_counter_if sw_w_if ();

    stopwatch_time_counter #(.TICK_DIV(4), .MIN_MAX(59)) dut (
        .clock100MHz(clk),
        .reset_n    (rst_n),
        .sw         (sw_if.slave)
    );

    // Same design with a one-minute span so the wrap path is reachable quickly.
    stopwatch_time_counter #(.TICK_DIV(1), .MIN_MAX(0)) dut_w (
        .clock100MHz(clk),
        .reset_n    (rst_n),
        .sw         (sw_w_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        ce;
        logic        clr;
        logic        spl;
        int          n;
        logic [23:0] disp;
        logic        held;
        logic        run;
        logic        roll;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [23:0] t(input int m, input int s, input int h);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic ce, input logic clr,
                                input logic spl, input int n, input logic [23:0] d,
                                input logic h, input logic run, input logic roll);
        vec_t v;
        v.name = nm; v.rst_n = r; v.ce = ce; v.clr = clr; v.spl = spl; v.n = n;
        v.disp = d; v.held = h; v.run = run; v.roll = roll;
        return v;
    endfunction

    task automatic check(input string nm,
                         input logic [23:0] ad, input logic [23:0] ed,
                         input logic ah, input logic eh,
                         input logic ar, input logic er,
                         input logic aro, input logic ero);
        vectors++;
        if (ad !== ed) begin
            miscompares++;
            $display("FAIL %s display: got %h want %h", nm, ad, ed);
        end
        if (ah !== eh) begin
            miscompares++;
            $display("FAIL %s held: got %b want %b", nm, ah, eh);
        end
        if (ar !== er) begin
            miscompares++;
            $display("FAIL %s running: got %b want %b", nm, ar, er);
        end
        if (aro !== ero) begin
            miscompares++;
            $display("FAIL %s rollover: got %b want %b", nm, aro, ero);
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        sw_if.count_Enable   = 1'b0;
        sw_if.clear          = 1'b0;
        sw_if.split          = 1'b0;
        sw_w_if.count_Enable = 1'b0;
        sw_w_if.clear        = 1'b0;
        sw_w_if.split        = 1'b0;

        //                  name        rst ce clr spl   n     display        held run roll
        vecs.push_back(mk("reset",      0, 0, 0, 0,    2, t(0, 0, 0),   0, 0, 0));
        // 100 ticks; display lags the counter by one edge
        vecs.push_back(mk("run400",     1, 1, 0, 0,  400, t(0, 0, 99),  0, 1, 0));
        vecs.push_back(mk("run400_lag", 1, 0, 0, 0,    1, t(0, 1, 0),   0, 0, 0));
        // pause mid-period keeps prescaler progress: 2 + 2 enabled cycles = one tick
        vecs.push_back(mk("pre_pause",  1, 1, 0, 0,    2, t(0, 1, 0),   0, 1, 0));
        vecs.push_back(mk("paused",     1, 0, 0, 0,   10, t(0, 1, 0),   0, 0, 0));
        vecs.push_back(mk("resume",     1, 1, 0, 0,    2, t(0, 1, 0),   0, 1, 0));
        vecs.push_back(mk("one_tick",   1, 0, 0, 0,    1, t(0, 1, 1),   0, 0, 0));
        vecs.push_back(mk("idle",       1, 0, 0, 0,    5, t(0, 1, 1),   0, 0, 0));
        // split hold at .05, release 40 cycles later at .15
        vecs.push_back(mk("clear1",     1, 0, 1, 0,    1, t(0, 0, 0),   0, 0, 0));
        vecs.push_back(mk("to_05",      1, 1, 0, 0,   20, t(0, 0, 4),   0, 1, 0));
        vecs.push_back(mk("split_05",   1, 1, 0, 1,    1, t(0, 0, 5),   1, 1, 0));
        vecs.push_back(mk("held_05",    1, 1, 0, 0,   39, t(0, 0, 5),   1, 1, 0));
        vecs.push_back(mk("unsplit_15", 1, 1, 0, 1,    1, t(0, 0, 15),  0, 1, 0));
        // split coinciding with the tick .07 -> .08 freezes .07
        vecs.push_back(mk("clear2",     1, 0, 1, 0,    1, t(0, 0, 0),   0, 0, 0));
        vecs.push_back(mk("to_07",      1, 1, 0, 0,   28, t(0, 0, 6),   0, 1, 0));
        vecs.push_back(mk("pre_tick",   1, 1, 0, 0,    3, t(0, 0, 7),   0, 1, 0));
        vecs.push_back(mk("split_tick", 1, 1, 0, 1,    1, t(0, 0, 7),   1, 1, 0));
        vecs.push_back(mk("held_07",    1, 1, 0, 0,    4, t(0, 0, 7),   1, 1, 0));
        // clear + split while held at 12.34
        vecs.push_back(mk("clear3",     1, 0, 1, 0,    1, t(0, 0, 0),   0, 0, 0));
        vecs.push_back(mk("to_1234",    1, 1, 0, 0, 4936, t(0, 12, 33), 0, 1, 0));
        vecs.push_back(mk("split_1234", 1, 1, 0, 1,    1, t(0, 12, 34), 1, 1, 0));
        vecs.push_back(mk("held_1234",  1, 1, 0, 0,    4, t(0, 12, 34), 1, 1, 0));
        vecs.push_back(mk("clr_split",  1, 1, 1, 1,    1, t(0, 0, 0),   0, 1, 0));
        vecs.push_back(mk("restart",    1, 1, 0, 0,    4, t(0, 0, 0),   0, 1, 0));
        vecs.push_back(mk("restart_01", 1, 1, 0, 0,    1, t(0, 0, 1),   0, 1, 0));
        // split while paused still toggles
        vecs.push_back(mk("psplit_on",  1, 0, 0, 1,    1, t(0, 0, 1),   1, 0, 0));
        vecs.push_back(mk("psplit_off", 1, 0, 0, 1,    1, t(0, 0, 1),   0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            rst_n              = vecs[i].rst_n;
            sw_if.count_Enable = vecs[i].ce;
            sw_if.clear        = vecs[i].clr;
            sw_if.split        = vecs[i].spl;
            repeat (vecs[i].n) @(negedge clk);
            check(vecs[i].name,
                  sw_if.display_Digits, vecs[i].disp,
                  sw_if.held, vecs[i].held,
                  sw_if.running, vecs[i].run,
                  sw_if.rollover, vecs[i].roll);
        end
        sw_if.split = 1'b0;

        // Wrap on the one-minute instance: one tick per edge, 00:59.99 after 5999 edges.
        sw_w_if.count_Enable = 1'b1;
        repeat (5999) @(negedge clk);
        check("w_pre_wrap", sw_w_if.display_Digits, t(0, 59, 98), sw_w_if.held, 1'b0,
              sw_w_if.running, 1'b1, sw_w_if.rollover, 1'b0);
        @(negedge clk);
        check("w_wrap", sw_w_if.display_Digits, t(0, 59, 99), sw_w_if.held, 1'b0,
              sw_w_if.running, 1'b1, sw_w_if.rollover, 1'b1);
        @(negedge clk);
        check("w_post_wrap", sw_w_if.display_Digits, t(0, 0, 0), sw_w_if.held, 1'b0,
              sw_w_if.running, 1'b1, sw_w_if.rollover, 1'b0);
        @(negedge clk);
        check("w_after", sw_w_if.display_Digits, t(0, 0, 1), sw_w_if.held, 1'b0,
              sw_w_if.running, 1'b1, sw_w_if.rollover, 1'b0);
        sw_w_if.count_Enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
